// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial add/subtract sequencer that drives one external single-bit
//   full adder. It accepts a W-bit operand pair and feeds the adder one bit
//   per cycle, LSB first. The carry is held in a register between bits, and
//   the W-bit result is assembled in place.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   IN_VALID/IN_READY   request handshake (IN_READY high only while idle)
//   OP_A, OP_B          operands, latched on the accept edge
//   CIN_IN, SUB         carry-in for add; SUB=1 computes A-B as A+~B+1
//   FA_A/FA_B/FA_CIN    bit k of latched A, B and the carry to the full adder
//   FA_S/FA_COUT        full adder sum and carry-out (combinational)
//   OUT_VALID/OUT_READY result handshake
//   SUM, COUT, OVF      result word, final carry, signed overflow
module serial_add_ctrl #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [W-1:0] OP_A,
   input  logic [W-1:0] OP_B,
   input  logic         CIN_IN,
   input  logic         SUB,
   output logic         FA_A,
   output logic         FA_B,
   output logic         FA_CIN,
   input  logic         FA_S,
   input  logic         FA_COUT,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [W-1:0] SUM,
   output logic         COUT,
   output logic         OVF
);

   localparam int K_W = $clog2(W);
   localparam logic [K_W-1:0] K_LAST = K_W'(W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t         state;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           carry;
   logic [K_W-1:0] k;

   // Operand copies: the request bus may change after the accept edge.
   // B is stored pre-inverted for subtraction.
   always_ff @(posedge CLK) begin
      if (state == IDLE && IN_VALID) begin
         a_q <= OP_A;
         b_q <= SUB ? ~OP_B : OP_B;
      end
   end

   // The adder inputs are driven only while a bit is being processed.
   always_comb begin
      FA_A   = 1'b0;
      FA_B   = 1'b0;
      FA_CIN = 1'b0;
      if (state == ADD) begin
         FA_A   = a_q[k];
         FA_B   = b_q[k];
         FA_CIN = carry;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         IN_READY  <= 1'b1;
         OUT_VALID <= 1'b0;
         SUM       <= '0;
         COUT      <= 1'b0;
         OVF       <= 1'b0;
         carry     <= 1'b0;
         k         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (IN_VALID) begin
                  carry    <= SUB ? 1'b1 : CIN_IN;
                  k        <= '0;
                  IN_READY <= 1'b0;
                  state    <= ADD;
               end
            end
            ADD: begin
               SUM[k] <= FA_S;
               carry  <= FA_COUT;
               if (k == K_LAST) begin
                  // carry still holds the carry into the MSB here
                  OVF       <= carry ^ FA_COUT;
                  COUT      <= FA_COUT;
                  k         <= '0;
                  OUT_VALID <= 1'b1;
                  state     <= HOLD;
               end else begin
                  k <= k + 1'b1;
               end
            end
            HOLD: begin
               if (OUT_READY) begin
                  OUT_VALID <= 1'b0;
                  IN_READY  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               IN_READY  <= 1'b1;
               OUT_VALID <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- W=8 instance ----------------
   logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8;
   logic [7:0] op_a8, op_b8, sum8;
   logic       fa_a8, fa_b8, fa_cin8, fa_s8, fa_cout8, cout8, ovf8;

   assign fa_s8    = fa_a8 ^ fa_b8 ^ fa_cin8;
   assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);

   serial_add_ctrl #(.W(8)) u8 (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid8), .IN_READY(in_ready8),
      .OP_A(op_a8), .OP_B(op_b8), .CIN_IN(cin8), .SUB(sub8),
      .FA_A(fa_a8), .FA_B(fa_b8), .FA_CIN(fa_cin8), .FA_S(fa_s8), .FA_COUT(fa_cout8),
      .OUT_VALID(out_valid8), .OUT_READY(out_ready8),
      .SUM(sum8), .COUT(cout8), .OVF(ovf8)
   );

   // ---------------- W=3 instance ----------------
   logic       in_valid3, in_ready3, cin3, sub3, out_valid3, out_ready3;
   logic [2:0] op_a3, op_b3, sum3;
   logic       fa_a3, fa_b3, fa_cin3, fa_s3, fa_cout3, cout3, ovf3;

   assign fa_s3    = fa_a3 ^ fa_b3 ^ fa_cin3;
   assign fa_cout3 = (fa_a3 & fa_b3) | (fa_a3 & fa_cin3) | (fa_b3 & fa_cin3);

   serial_add_ctrl #(.W(3)) u3 (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid3), .IN_READY(in_ready3),
      .OP_A(op_a3), .OP_B(op_b3), .CIN_IN(cin3), .SUB(sub3),
      .FA_A(fa_a3), .FA_B(fa_b3), .FA_CIN(fa_cin3), .FA_S(fa_s3), .FA_COUT(fa_cout3),
      .OUT_VALID(out_valid3), .OUT_READY(out_ready3),
      .SUM(sum3), .COUT(cout3), .OVF(ovf3)
   );

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } res8_t;

   typedef struct packed {
      logic [2:0] sum;
      logic       cout;
      logic       ovf;
   } res3_t;

   res8_t q8[$];
   res3_t q3[$];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a W=8 request, wait for the accept edge, then scramble the bus.
   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s, input res8_t exp);
      @(negedge clk);
      chk("in_ready_before_accept", in_ready8, 1'b1);
      in_valid8 = 1'b1; op_a8 = a; op_b8 = b; cin8 = c; sub8 = s;
      @(negedge clk);
      in_valid8 = 1'b0;
      op_a8 = 8'($urandom); op_b8 = 8'($urandom); cin8 = ~c; sub8 = ~s;
      q8.push_back(exp);
   endtask

   // Wait (bounded) for OUT_VALID, check latency and result against the queue.
   task automatic wait_result8(input string tag);
      int n;
      res8_t e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid8 && n < 40);
      chk({tag, "_latency"}, n, 8);
      if (q8.size() > 0) begin
         e = q8.pop_front();
         chk({tag, "_sum"},  sum8,  e.sum);
         chk({tag, "_cout"}, cout8, e.cout);
         chk({tag, "_ovf"},  ovf8,  e.ovf);
      end else begin
         chk({tag, "_scoreboard_empty"}, q8.size(), 1);
      end
   endtask

   task automatic ack8(input string tag);
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      chk({tag, "_ack_out_valid"}, out_valid8, 1'b0);
      chk({tag, "_ack_in_ready"},  in_ready8,  1'b1);
   endtask

   initial begin
      logic [7:0] hold_sum;
      logic       hold_cout, hold_ovf;
      int         n;
      logic [2:0] bb;
      logic       c0, cy;
      logic [3:0] full;
      res3_t      e3, r3;

      rst = 1'b1;
      in_valid8 = 1'b0; out_ready8 = 1'b0; op_a8 = '0; op_b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      in_valid3 = 1'b0; out_ready3 = 1'b0; op_a3 = '0; op_b3 = '0; cin3 = 1'b0; sub3 = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_in_ready",  in_ready8,  1'b1);
      chk("rst_out_valid", out_valid8, 1'b0);
      chk("rst_sum",       sum8,       8'h00);
      chk("rst_cout",      cout8,      1'b0);
      chk("rst_ovf",       ovf8,       1'b0);
      chk("rst_fa",        {fa_a8, fa_b8, fa_cin8}, 3'b000);
      rst = 1'b0;

      // Directed adds and subtracts
      start8(8'h0F, 8'h01, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b0});
      wait_result8("add_0f_01");
      ack8("add_0f_01");

      start8(8'hFF, 8'h01, 1'b1, 1'b0, '{8'h01, 1'b1, 1'b0});
      wait_result8("add_ff_01_c1");
      ack8("add_ff_01_c1");

      start8(8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1});
      wait_result8("add_7f_01");
      ack8("add_7f_01");

      start8(8'h05, 8'h07, 1'b0, 1'b1, '{8'hFE, 1'b0, 1'b0});
      wait_result8("sub_05_07_c0");
      ack8("sub_05_07_c0");

      start8(8'h05, 8'h07, 1'b1, 1'b1, '{8'hFE, 1'b0, 1'b0});
      wait_result8("sub_05_07_c1");
      ack8("sub_05_07_c1");

      start8(8'h07, 8'h05, 1'b1, 1'b1, '{8'h02, 1'b1, 1'b0});
      wait_result8("sub_07_05_c1");
      ack8("sub_07_05_c1");

      start8(8'h80, 8'h01, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b1});
      wait_result8("sub_80_01");
      ack8("sub_80_01");

      // Backpressure: result stays put, new requests are refused
      start8(8'h3C, 8'h5A, 1'b1, 1'b0, '{8'h97, 1'b0, 1'b1});
      wait_result8("bp");
      hold_sum = sum8; hold_cout = cout8; hold_ovf = ovf8;
      for (int i = 0; i < 5; i++) begin
         in_valid8 = 1'b1; op_a8 = 8'hAA; op_b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b0;
         @(negedge clk);
         chk("bp_sum_stable",  sum8,       hold_sum);
         chk("bp_cout_stable", cout8,      hold_cout);
         chk("bp_ovf_stable",  ovf8,       hold_ovf);
         chk("bp_in_ready",    in_ready8,  1'b0);
         chk("bp_out_valid",   out_valid8, 1'b1);
      end
      in_valid8 = 1'b0;
      ack8("bp");
      chk("bp_sum_after_ack", sum8, hold_sum);
      @(negedge clk);
      chk("bp_still_idle", in_ready8, 1'b1);

      // Reset in the middle of an operation
      start8(8'h12, 8'h34, 1'b0, 1'b0, '{8'h46, 1'b0, 1'b0});
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready",  in_ready8,  1'b1);
      chk("midrst_out_valid", out_valid8, 1'b0);
      chk("midrst_sum",       sum8,       8'h00);
      chk("midrst_fa",        {fa_a8, fa_b8, fa_cin8}, 3'b000);
      void'(q8.pop_front());
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid8) n++;
      end
      chk("midrst_no_out_valid", n, 0);

      start8(8'hC8, 8'h64, 1'b0, 1'b0, '{8'h2C, 1'b1, 1'b0});
      wait_result8("after_rst");
      ack8("after_rst");

      // Exhaustive W=3 against a word-level reference model
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 8; a++) begin
               for (int b = 0; b < 8; b++) begin
                  @(negedge clk);
                  in_valid3 = 1'b1; op_a3 = 3'(a); op_b3 = 3'(b); cin3 = 1'(c); sub3 = 1'(s);
                  bb   = (s != 0) ? ~3'(b) : 3'(b);
                  c0   = (s != 0) ? 1'b1 : 1'(c);
                  full = {1'b0, 3'(a)} + {1'b0, bb} + {3'b000, c0};
                  e3.sum  = full[2:0];
                  e3.cout = full[3];
                  e3.ovf  = (op_a3[2] == bb[2]) && (full[2] != op_a3[2]);
                  @(negedge clk);
                  in_valid3 = 1'b0; op_a3 = 3'($urandom); op_b3 = 3'($urandom);
                  q3.push_back(e3);
                  cy = c0;
                  for (int i = 0; i < 3; i++) begin
                     chk($sformatf("w3_fa_s%0d_c%0d_a%0d_b%0d_bit%0d", s, c, a, b, i),
                         {fa_a3, fa_b3, fa_cin3}, {op_a3 === op_a3 ? 1'(a >> i) : 1'b0, bb[i], cy});
                     cy = (1'(a >> i) & bb[i]) | (1'(a >> i) & cy) | (bb[i] & cy);
                     @(negedge clk);
                  end
                  chk("w3_out_valid", out_valid3, 1'b1);
                  chk("w3_fa_idle",   {fa_a3, fa_b3, fa_cin3}, 3'b000);
                  r3 = q3.pop_front();
                  chk($sformatf("w3_res_s%0d_c%0d_a%0d_b%0d", s, c, a, b),
                      {sum3, cout3, ovf3}, {r3.sum, r3.cout, r3.ovf});
                  out_ready3 = 1'b1;
                  @(negedge clk);
                  out_ready3 = 1'b0;
               end
            end
         end
      end
      chk("w3_back_idle", in_ready3, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
